apb_cmd_sequencer: RTL and testbench

Command queue and issue sequencer that sits directly upstream of the APB master/slave top. It accepts read/write commands from a producer over a valid/ready handshake and buffers them in a small FIFO. It drives the top's `add_i`/`external_wdata_i` one transaction at a time, waits for the slave ready, and returns each completion (read data or timeout error) as a one-cycle response pulse.

---
 rtl/apb_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_apb_cmd_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_sequencer.sv
// Purpose: buffers READ/WRITE commands and issues them one at a time to the APB top.
// Latency: a command reaches add_o two edges after its push; the response follows ready by one edge.
// Backpressure: cmd_ready_o drops while the FIFO is full; responses have no backpressure.
module apb_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                   pclk,
    input  logic                   preset,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic                   cmd_write_i,
    input  logic [DATA_W-1:0]      cmd_wdata_i,
    output logic [1:0]             add_o,
    output logic [DATA_W-1:0]      wdata_o,
    input  logic                   apb_ready_i,
    input  logic [DATA_W-1:0]      apb_rdata_i,
    output logic                   rsp_valid_o,
    output logic                   rsp_write_o,
    output logic                   rsp_err_o,
    output logic [DATA_W-1:0]      rsp_rdata_o,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [1:0] ADD_NOP   = 2'b00;
    localparam logic [1:0] ADD_READ  = 2'b01;
    localparam logic [1:0] ADD_WRITE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              fifo_write [DEPTH];
    logic [DATA_W-1:0] fifo_wdata [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              issue_write_q;
    logic [WAIT_W-1:0] wait_q;

    logic push, pop, done, timed_out;

    // Full check uses the registered count only, so a pop never opens a slot in the same cycle.
    assign cmd_ready_o = (count_q != CNT_FULL);
    assign push        = cmd_valid_i && cmd_ready_o;
    assign count_o     = count_q;
    assign busy_o      = (state_q != S_IDLE) || (count_q != '0);

    // Next-state decode: pop in IDLE, finish ISSUE on ready (not in the setup cycle) or on timeout.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        done      = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // wait_q is zero only in the setup cycle, where ready may be stale.
                if ((wait_q != '0) && apb_ready_i) begin
                    done    = 1'b1;
                    state_d = S_GAP;
                end else if (wait_q == WAIT_LAST) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers and count gate every read.
    always_ff @(posedge pclk) begin
        if (push) begin
            fifo_write[wr_ptr_q] <= cmd_write_i;
            fifo_wdata[wr_ptr_q] <= cmd_wdata_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge pclk) begin
        if (preset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Issue register, wait counter, APB drive and response capture.
    always_ff @(posedge pclk) begin
        if (preset) begin
            issue_write_q <= 1'b0;
            wait_q        <= '0;
            add_o         <= ADD_NOP;
            wdata_o       <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_write_o   <= 1'b0;
            rsp_err_o     <= 1'b0;
            rsp_rdata_o   <= '0;
        end else begin
            rsp_valid_o <= done;
            if (pop) begin
                issue_write_q <= fifo_write[rd_ptr_q];
                add_o         <= fifo_write[rd_ptr_q] ? ADD_WRITE : ADD_READ;
                wdata_o       <= fifo_write[rd_ptr_q] ? fifo_wdata[rd_ptr_q] : '0;
                wait_q        <= '0;
            end else if ((state_q == S_ISSUE) && (wait_q != WAIT_MAX)) begin
                wait_q <= wait_q + WAIT_W'(1);
            end
            if (done) begin
                // Dropping add_o here gives the master a full idle cycle during GAP.
                add_o       <= ADD_NOP;
                wdata_o     <= '0;
                rsp_write_o <= issue_write_q;
                rsp_err_o   <= timed_out;
                rsp_rdata_o <= (issue_write_q || timed_out) ? '0 : apb_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Purpose: randomized scoreboard bench for apb_cmd_sequencer with a behavioural APB slave.
// Latency: expected responses are queued at issue start and matched when rsp_valid_o pulses.
// Backpressure: the producer holds cmd_valid_i until cmd_ready_o, bounded by a cycle budget.
module tb_apb_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    typedef struct {
        bit          w;
        logic [31:0] d;
    } cmd_t;

    typedef struct {
        bit          w;
        bit          err;
        logic [31:0] rd;
    } rsp_t;

    logic              pclk;
    logic              preset;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic [1:0]        add_o;
    logic [DATA_W-1:0] wdata_o;
    logic              apb_ready_i;
    logic [DATA_W-1:0] apb_rdata_i;
    logic              rsp_valid_o;
    logic              rsp_write_o;
    logic              rsp_err_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              busy_o;
    logic [$clog2(DEPTH):0] count_o;

    apb_cmd_sequencer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_write_i (cmd_write_i),
        .cmd_wdata_i (cmd_wdata_i),
        .add_o       (add_o),
        .wdata_o     (wdata_o),
        .apb_ready_i (apb_ready_i),
        .apb_rdata_i (apb_rdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_write_o (rsp_write_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_rdata_o (rsp_rdata_o),
        .busy_o      (busy_o),
        .count_o     (count_o)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int checks   = 0;
    int failures = 0;

    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    int   force_q[$];

    int n_acc = 0;
    int n_iss = 0;
    bit stale = 1'b0;
    bit fixed_rd_en = 1'b0;
    logic [31:0] fixed_rd = 32'h1234_5678;
    bit saw_full = 1'b0;

    // slave / monitor tracking
    int          k = 0;
    int          cur_l = 0;
    int          cur_len = 0;
    bit          cur_spur = 1'b0;
    logic [1:0]  cur_add = 2'b00;
    logic [31:0] cur_wdata = '0;
    logic [31:0] cur_rd = '0;
    logic [1:0]  prev_add = 2'b00;
    bit          prev_rsp = 1'b0;
    int          since_rsp = 100;
    int          exp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Behavioural APB slave plus response/occupancy monitor, evaluated just after each falling edge.
    initial begin
        cmd_t c;
        rsp_t r;
        rsp_t got;
        int   eff;
        int   sel;
        apb_ready_i = 1'b0;
        apb_rdata_i = '0;
        forever begin
            @(negedge pclk);
            #1;
            if (preset) begin
                cmd_q.delete();
                rsp_q.delete();
                n_iss     = 0;
                k         = 0;
                prev_add  = 2'b00;
                prev_rsp  = 1'b0;
                since_rsp = 100;
                apb_ready_i = 1'b0;
            end else begin
                since_rsp++;
                if (rsp_valid_o) begin
                    chk("rsp_single_pulse", prev_rsp, 0);
                    chk("rsp_add_idle", add_o, 2'b00);
                    chk("rsp_follows_issue", (prev_add != 2'b00), 1);
                    chk("rsp_spacing", (since_rsp >= 4), 1);
                    since_rsp = 0;
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", 1, 0);
                    end else begin
                        got = rsp_q.pop_front();
                        chk("rsp_write", rsp_write_o, got.w);
                        chk("rsp_err", rsp_err_o, got.err);
                        chk("rsp_rdata", rsp_rdata_o, got.rd);
                    end
                end
                if (add_o != 2'b00) begin
                    if (prev_add == 2'b00) begin
                        n_iss++;
                        if (cmd_q.size() == 0) begin
                            chk("issue_unexpected", 1, 0);
                            c.w = add_o[1];
                            c.d = wdata_o;
                        end else begin
                            c = cmd_q.pop_front();
                        end
                        cur_add   = c.w ? 2'b11 : 2'b01;
                        cur_wdata = c.w ? c.d : 32'h0;
                        chk("issue_add", add_o, cur_add);
                        chk("issue_wdata", wdata_o, cur_wdata);
                        k = 1;
                        if (force_q.size() != 0) begin
                            cur_l = force_q.pop_front();
                        end else begin
                            sel = $urandom_range(0, 9);
                            if (sel < 6)      cur_l = $urandom_range(1, 5);
                            else if (sel < 8) cur_l = $urandom_range(6, TIMEOUT);
                            else              cur_l = $urandom_range(TIMEOUT + 1, TIMEOUT + 4);
                        end
                        cur_spur = ($urandom_range(0, 1) == 1);
                        cur_rd   = fixed_rd_en ? fixed_rd : $urandom;
                        // ready is never honoured in the setup cycle, so the earliest finish is cycle 2
                        eff = stale ? 2 : ((cur_l < 2) ? 2 : cur_l);
                        r.w = c.w;
                        if (eff <= TIMEOUT) begin
                            cur_len = eff;
                            r.err   = 1'b0;
                        end else begin
                            cur_len = TIMEOUT;
                            r.err   = 1'b1;
                        end
                        r.rd = (c.w || r.err) ? 32'h0 : cur_rd;
                        rsp_q.push_back(r);
                    end else begin
                        k++;
                        chk("issue_hold_add", add_o, cur_add);
                        chk("issue_hold_wdata", wdata_o, cur_wdata);
                        if (k == cur_len + 1) chk("issue_too_long", k, cur_len);
                    end
                    apb_ready_i = stale || (k >= cur_l) || ((k == 1) && cur_spur);
                    apb_rdata_i = cur_rd;
                    chk("busy_in_issue", busy_o, 1);
                end else begin
                    if (prev_add != 2'b00) chk("issue_len", k, cur_len);
                    chk("idle_wdata", wdata_o, 0);
                    apb_ready_i = stale;
                    apb_rdata_i = $urandom;
                end
                exp_cnt = n_acc - n_iss;
                chk("count", count_o, exp_cnt);
                chk("cmd_ready", cmd_ready_o, (exp_cnt != DEPTH));
                if (exp_cnt != 0) chk("busy_queued", busy_o, 1);
                if (exp_cnt == DEPTH) saw_full = 1'b1;
                prev_add = add_o;
                prev_rsp = rsp_valid_o;
            end
        end
    end

    task automatic send(input bit w, input logic [31:0] d);
        int g = 0;
        cmd_valid_i = 1'b1;
        cmd_write_i = w;
        cmd_wdata_i = d;
        while (!cmd_ready_o && g < 500) begin
            @(negedge pclk);
            g++;
        end
        if (!cmd_ready_o) begin
            chk("push_accept_timeout", cmd_ready_o, 1);
            cmd_valid_i = 1'b0;
            return;
        end
        cmd_q.push_back('{w, d});
        @(negedge pclk);
        n_acc++;
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int g = 0; g < 3000; g++) begin
            @(negedge pclk);
            #2;
            if (cmd_q.size() == 0 && rsp_q.size() == 0 && busy_o == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_done", ok, 1);
    endtask

    initial begin
        bit found;
        preset      = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_wdata_i = '0;

        // reset values
        repeat (3) @(negedge pclk);
        #2;
        chk("rst_add", add_o, 2'b00);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_write", rsp_write_o, 0);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_rsp_rdata", rsp_rdata_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        preset = 1'b0;
        @(negedge pclk);

        // single WRITE then READ, slave ready on the second ISSUE cycle
        fixed_rd_en = 1'b1;
        force_q.push_back(2);
        force_q.push_back(2);
        send(1'b1, 32'hDEAD_BEEF);
        send(1'b0, 32'h5555_AAAA);
        drain();
        fixed_rd_en = 1'b0;

        // timeout on a READ, then a WRITE must still issue normally
        force_q.push_back(TIMEOUT + 3);
        force_q.push_back(3);
        send(1'b0, 32'h0);
        send(1'b1, 32'hCAFE_F00D);
        drain();

        // back-to-back burst against a slow slave fills the FIFO
        saw_full = 1'b0;
        for (int i = 0; i < 6; i++) force_q.push_back(8);
        for (int i = 0; i < 6; i++) send(i[0], $urandom);
        chk("fifo_reached_full", saw_full, 1);
        drain();

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge pclk);
            send(($urandom_range(0, 1) == 1), $urandom);
        end
        drain();

        // stale ready held high: every ISSUE lasts exactly two cycles
        stale = 1'b1;
        for (int i = 0; i < 6; i++) send(($urandom_range(0, 1) == 1), $urandom);
        drain();
        stale = 1'b0;

        // reset during the second ISSUE cycle with two commands queued
        for (int i = 0; i < 3; i++) force_q.push_back(100);
        for (int i = 0; i < 3; i++) send(1'b0, $urandom);
        found = 1'b0;
        for (int g = 0; g < 50; g++) begin
            #2;
            if (k == 2 && add_o != 2'b00) begin
                found = 1'b1;
                break;
            end
            @(negedge pclk);
        end
        chk("reach_issue2", found, 1);
        chk("queued_before_reset", count_o, 2);
        preset = 1'b1;
        n_acc  = 0;
        @(negedge pclk);
        #2;
        chk("mid_rst_add", add_o, 2'b00);
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_cmd_ready", cmd_ready_o, 1);
        chk("mid_rst_rsp_valid", rsp_valid_o, 0);
        force_q.delete();
        preset = 1'b0;
        @(negedge pclk);

        // recovery after reset
        for (int i = 0; i < 5; i++) send(($urandom_range(0, 1) == 1), $urandom);
        drain();
        repeat (5) @(negedge pclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
